// File: rtl/seg_reader_if.sv
// -----------------------------------------------------------------------------
// seg_reader_if
// Purpose : groups the sample strobe, the raw seven-segment bus and all
//           decoded/status outputs of seg_reader into one bundle.
// Signals :
//   sample_en        sample strobe (driven by master)
//   dec[6:0]         active-low seven-segment bus, bit6 = a ... bit0 = g
//   bcd[2:0]         last accepted digit 0..7
//   valid            one-cycle pulse on a newly accepted digit
//   step_up/down     one-cycle pulses for +1 / -1 changes
//   jump             one-cycle pulse for any other change
//   err              level, high while in FAULT
//   at_limit         level, high while LOCKED at 0 or 7
//   up_cnt/down_cnt  step pulse counters (only with SEG_READER_STATS_EN)
// Modports: master (stimulus side), slave (seg_reader side).
// Optional feature macro: SEG_READER_STATS_EN
// -----------------------------------------------------------------------------
interface seg_reader_if;
   logic       sample_en;
   logic [6:0] dec;
   logic [2:0] bcd;
   logic       valid;
   logic       step_up;
   logic       step_down;
   logic       jump;
   logic       err;
   logic       at_limit;
`ifdef SEG_READER_STATS_EN
   logic [7:0] up_cnt;
   logic [7:0] down_cnt;
`endif

   modport master (
      output sample_en,
      output dec,
      input  bcd,
      input  valid,
      input  step_up,
      input  step_down,
      input  jump,
      input  err,
      input  at_limit
`ifdef SEG_READER_STATS_EN
      ,
      input  up_cnt,
      input  down_cnt
`endif
   );

   modport slave (
      input  sample_en,
      input  dec,
      output bcd,
      output valid,
      output step_up,
      output step_down,
      output jump,
      output err,
      output at_limit
`ifdef SEG_READER_STATS_EN
      ,
      output up_cnt,
      output down_cnt
`endif
   );
endinterface

// File: rtl/seg_reader.sv
// -----------------------------------------------------------------------------
// seg_reader
// Purpose : reads an asynchronous active-low seven-segment bus, synchronizes
//           it, debounces it over STABLE_CYCLES sample strobes, decodes digits
//           0..7 and reports accepted digits plus step/jump classification.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    seg_reader_if.slave (sample_en, dec in; bcd, valid, step_up,
//          step_down, jump, err, at_limit [, up_cnt, down_cnt] out)
// Parameter: STABLE_CYCLES (1..15) strobes a pattern must hold to be accepted.
// Optional feature macro: SEG_READER_STATS_EN adds saturating up_cnt/down_cnt.
// -----------------------------------------------------------------------------
module seg_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   seg_reader_if.slave bus
);
   localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_LOCKED = 2'd1,
      S_FAULT  = 2'd2
   } state_t;

   logic [6:0] r_sync1, r_sync2, r_cand;
   logic [3:0] r_cnt;
   state_t     r_state;
   logic [2:0] r_bcd;
   logic       r_valid, r_step_up, r_step_down, r_jump, r_err, r_at_limit;

   logic [6:0] w_cand_next;
   logic [3:0] w_cnt_next;
   logic       w_qual;
   logic       w_dec_ok;
   logic [2:0] w_dec_val;
   logic       w_is_up, w_is_down;
   state_t     w_state_next;
   logic [2:0] w_bcd_next;
   logic       w_valid_next, w_step_up_next, w_step_down_next, w_jump_next;
   logic       w_err_next, w_at_limit_next;

   // Stability filter: the qualify strobe fires only on the transition of the
   // count into STABLE_CYCLES, so a held pattern is reported once.
   always_comb begin
      w_cand_next = r_cand;
      w_cnt_next  = r_cnt;
      w_qual      = 1'b0;
      if (bus.sample_en) begin
         if (r_sync2 == r_cand) begin
            if (r_cnt < LP_STABLE) begin
               w_cnt_next = r_cnt + 4'd1;
               w_qual     = ((r_cnt + 4'd1) == LP_STABLE);
            end
         end else begin
            w_cand_next = r_sync2;
            w_cnt_next  = 4'd1;
            w_qual      = (LP_STABLE == 4'd1);
         end
      end
   end

   // Decode of the pattern being qualified (active-low segments).
   always_comb begin
      w_dec_ok  = 1'b1;
      w_dec_val = 3'd0;
      case (w_cand_next)
         7'h01:   w_dec_val = 3'd0;
         7'h4F:   w_dec_val = 3'd1;
         7'h12:   w_dec_val = 3'd2;
         7'h06:   w_dec_val = 3'd3;
         7'h4C:   w_dec_val = 3'd4;
         7'h24:   w_dec_val = 3'd5;
         7'h20:   w_dec_val = 3'd6;
         7'h0F:   w_dec_val = 3'd7;
         default: w_dec_ok  = 1'b0;
      endcase
   end

   // Widened compare so 7->0 and 0->7 never look like single steps.
   assign w_is_up   = ({1'b0, w_dec_val} == ({1'b0, r_bcd} + 4'd1));
   assign w_is_down = ({1'b0, r_bcd} == ({1'b0, w_dec_val} + 4'd1));

   // Next-state and registered-output logic.
   always_comb begin
      w_state_next     = r_state;
      w_bcd_next       = r_bcd;
      w_valid_next     = 1'b0;
      w_step_up_next   = 1'b0;
      w_step_down_next = 1'b0;
      w_jump_next      = 1'b0;
      if (w_qual) begin
         if (!w_dec_ok) begin
            w_state_next = S_FAULT;
         end else begin
            case (r_state)
               S_LOCKED: begin
                  if (w_dec_val != r_bcd) begin
                     w_bcd_next       = w_dec_val;
                     w_valid_next     = 1'b1;
                     w_step_up_next   = w_is_up;
                     w_step_down_next = w_is_down;
                     w_jump_next      = !w_is_up && !w_is_down;
                  end
               end
               default: begin
                  // INIT or FAULT: first accepted digit has no reference.
                  w_bcd_next   = w_dec_val;
                  w_valid_next = 1'b1;
                  w_state_next = S_LOCKED;
               end
            endcase
         end
      end
      w_err_next      = (w_state_next == S_FAULT);
      w_at_limit_next = (w_state_next == S_LOCKED) &&
                        ((w_bcd_next == 3'd0) || (w_bcd_next == 3'd7));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1     <= 7'h7F;
         r_sync2     <= 7'h7F;
         r_cand      <= 7'h7F;
         r_cnt       <= 4'd0;
         r_state     <= S_INIT;
         r_bcd       <= 3'd0;
         r_valid     <= 1'b0;
         r_step_up   <= 1'b0;
         r_step_down <= 1'b0;
         r_jump      <= 1'b0;
         r_err       <= 1'b0;
         r_at_limit  <= 1'b0;
      end else begin
         r_sync1     <= bus.dec;
         r_sync2     <= r_sync1;
         r_cand      <= w_cand_next;
         r_cnt       <= w_cnt_next;
         r_state     <= w_state_next;
         r_bcd       <= w_bcd_next;
         r_valid     <= w_valid_next;
         r_step_up   <= w_step_up_next;
         r_step_down <= w_step_down_next;
         r_jump      <= w_jump_next;
         r_err       <= w_err_next;
         r_at_limit  <= w_at_limit_next;
      end
   end

   assign bus.bcd       = r_bcd;
   assign bus.valid     = r_valid;
   assign bus.step_up   = r_step_up;
   assign bus.step_down = r_step_down;
   assign bus.jump      = r_jump;
   assign bus.err       = r_err;
   assign bus.at_limit  = r_at_limit;

`ifdef SEG_READER_STATS_EN
   logic [7:0] r_up_cnt, r_down_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_up_cnt   <= 8'd0;
         r_down_cnt <= 8'd0;
      end else begin
         if (w_step_up_next && (r_up_cnt != 8'hFF))
            r_up_cnt <= r_up_cnt + 8'd1;
         if (w_step_down_next && (r_down_cnt != 8'hFF))
            r_down_cnt <= r_down_cnt + 8'd1;
      end
   end

   assign bus.up_cnt   = r_up_cnt;
   assign bus.down_cnt = r_down_cnt;
`endif
endmodule

// File: tb/tb_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seg_reader
// Purpose : self-checking bench for seg_reader (STABLE_CYCLES = 4): directed
//           table rows, hand-written multi-cycle sequences, and randomized
//           stimulus compared against a behavioural model.
// Optional feature macro: SEG_READER_STATS_EN (counter checks enabled).
// -----------------------------------------------------------------------------
module tb_seg_reader;
   localparam int STABLE = 4;

   logic clk;
   logic reset;
   seg_reader_if bus ();

   seg_reader #(.STABLE_CYCLES(STABLE)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [6:0] pat_tbl [0:7];

   // Behavioural model state
   logic [6:0] m_hist [0:1];
   logic [6:0] m_run_pat;
   int         m_run_len;
   int         m_mode;      // 0 = waiting for first digit, 1 = locked, 2 = fault
   int         m_bcd;
   bit         m_valid, m_up, m_down, m_jump;
   int         m_up_cnt, m_down_cnt;

   typedef struct {
      logic [6:0] dec;
      int n_valid;
      int n_up;
      int n_down;
      int n_jump;
      int bcd;
      int err;
      int lim;
   } row_t;

   row_t rows [0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int find_digit(input logic [6:0] p);
      for (int i = 0; i < 8; i++)
         if (pat_tbl[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_hist[0] = 7'h7F;
      m_hist[1] = 7'h7F;
      m_run_pat = 7'h7F;
      m_run_len = 0;
      m_mode = 0;
      m_bcd = 0;
      m_valid = 0; m_up = 0; m_down = 0; m_jump = 0;
      m_up_cnt = 0; m_down_cnt = 0;
   endtask

   // One rising edge of behaviour, from the rules in plain terms.
   task automatic model_step();
      logic [6:0] seen;
      bit qual;
      int idx;
      int diff;
      if (!reset) begin
         model_reset();
         return;
      end
      seen = m_hist[0];
      m_hist[0] = m_hist[1];
      m_hist[1] = bus.dec;
      m_valid = 0; m_up = 0; m_down = 0; m_jump = 0;
      qual = 0;
      if (bus.sample_en) begin
         if (seen == m_run_pat) begin
            m_run_len++;
            qual = (m_run_len == STABLE);
         end else begin
            m_run_pat = seen;
            m_run_len = 1;
            qual = (STABLE == 1);
         end
      end
      if (qual) begin
         idx = find_digit(m_run_pat);
         if (idx < 0) begin
            m_mode = 2;
         end else if (m_mode == 1) begin
            if (idx != m_bcd) begin
               diff = idx - m_bcd;
               m_valid = 1;
               m_up = (diff == 1);
               m_down = (diff == -1);
               m_jump = (diff != 1) && (diff != -1);
               m_bcd = idx;
            end
         end else begin
            m_valid = 1;
            m_bcd = idx;
            m_mode = 1;
         end
      end
      if (m_up && m_up_cnt < 255) m_up_cnt++;
      if (m_down && m_down_cnt < 255) m_down_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic logic [31:0] dut_vec();
      logic [31:0] v;
      v = {23'd0, bus.bcd, bus.valid, bus.step_up, bus.step_down, bus.jump, bus.err, bus.at_limit};
`ifdef SEG_READER_STATS_EN
      v[24:9] = {bus.up_cnt, bus.down_cnt};
`endif
      return v;
   endfunction

   function automatic logic [31:0] model_vec();
      logic [31:0] v;
      bit lim;
      lim = (m_mode == 1) && (m_bcd == 0 || m_bcd == 7);
      v = {23'd0, 3'(m_bcd), m_valid, m_up, m_down, m_jump, (m_mode == 2), lim};
`ifdef SEG_READER_STATS_EN
      v[24:9] = {8'(m_up_cnt), 8'(m_down_cnt)};
`endif
      return v;
   endfunction

   initial begin
      int first_valid;
      int nv, nu, nd, nj;
      int hold;
      int sel;

      pat_tbl[0] = 7'h01; pat_tbl[1] = 7'h4F; pat_tbl[2] = 7'h12; pat_tbl[3] = 7'h06;
      pat_tbl[4] = 7'h4C; pat_tbl[5] = 7'h24; pat_tbl[6] = 7'h20; pat_tbl[7] = 7'h0F;

      //          dec    valid up down jump bcd err lim
      rows[0] = '{7'h06, 1, 0, 0, 1, 3, 0, 0};
      rows[1] = '{7'h4C, 1, 1, 0, 0, 4, 0, 0};
      rows[2] = '{7'h06, 1, 0, 1, 0, 3, 0, 0};
      rows[3] = '{7'h0F, 1, 0, 0, 1, 7, 0, 1};
      rows[4] = '{7'h01, 1, 0, 0, 1, 0, 0, 1};
      rows[5] = '{7'h7F, 0, 0, 0, 0, 0, 1, 0};
      rows[6] = '{7'h24, 1, 0, 0, 0, 5, 0, 0};
      rows[7] = '{7'h12, 1, 0, 0, 1, 2, 0, 0};

      model_reset();
      reset = 1'b0;
      bus.sample_en = 1'b0;
      bus.dec = 7'h7F;
      #2;
      check("reset_state", dut_vec(), 32'd0);
      repeat (3) tick();

      // Power-up acceptance latency: 2 sync edges + 4 strobes.
      reset = 1'b1;
      bus.dec = 7'h01;
      bus.sample_en = 1'b1;
      first_valid = 0;
      nu = 0; nd = 0; nj = 0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (bus.valid && first_valid == 0) first_valid = e;
         nu += int'(bus.step_up); nd += int'(bus.step_down); nj += int'(bus.jump);
      end
      check("first_valid_edge", first_valid, 6);
      check("first_bcd", 32'(bus.bcd), 0);
      check("first_at_limit", 32'(bus.at_limit), 1);
      check("first_no_step_jump", nu + nd + nj, 0);

      // Directed table rows, each pattern held for 8 strobes.
      for (int r = 0; r < 8; r++) begin
         bus.dec = rows[r].dec;
         nv = 0; nu = 0; nd = 0; nj = 0;
         for (int c = 0; c < 8; c++) begin
            tick();
            nv += int'(bus.valid); nu += int'(bus.step_up);
            nd += int'(bus.step_down); nj += int'(bus.jump);
         end
         check($sformatf("row%0d_valid", r), nv, rows[r].n_valid);
         check($sformatf("row%0d_up", r), nu, rows[r].n_up);
         check($sformatf("row%0d_down", r), nd, rows[r].n_down);
         check($sformatf("row%0d_jump", r), nj, rows[r].n_jump);
         check($sformatf("row%0d_bcd", r), 32'(bus.bcd), rows[r].bcd);
         check($sformatf("row%0d_err", r), 32'(bus.err), rows[r].err);
         check($sformatf("row%0d_at_limit", r), 32'(bus.at_limit), rows[r].lim);
      end
`ifdef SEG_READER_STATS_EN
      check("stats_up_cnt", 32'(bus.up_cnt), 1);
      check("stats_down_cnt", 32'(bus.down_cnt), 1);
`endif

      // Pattern toggling every 3 strobes never qualifies.
      nv = 0;
      for (int t = 0; t < 36; t++) begin
         bus.dec = ((t / 3) % 2 == 0) ? 7'h06 : 7'h12;
         tick();
         nv += int'(bus.valid);
      end
      check("toggle_no_valid", nv, 0);
      check("toggle_bcd_hold", 32'(bus.bcd), 2);

      // Reset mid-filter discards the partial run.
      bus.dec = 7'h4C;
      repeat (4) tick();
      reset = 1'b0;
      #1;
      check("midreset_outputs", dut_vec(), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      first_valid = 0;
      nu = 0; nd = 0; nj = 0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (bus.valid && first_valid == 0) first_valid = e;
         nu += int'(bus.step_up); nd += int'(bus.step_down); nj += int'(bus.jump);
      end
      check("midreset_first_valid_edge", first_valid, 6);
      check("midreset_bcd", 32'(bus.bcd), 4);
      check("midreset_no_step_jump", nu + nd + nj, 0);

      // Randomized run against the model.
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) bus.dec = pat_tbl[sel];
            else if (sel == 8) bus.dec = 7'h7F;
            else bus.dec = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 7);
         end
         hold--;
         bus.sample_en = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 299) != 0);
         tick();
         reset = 1'b1;
         check($sformatf("rand_cycle%0d", c), dut_vec(), model_vec());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning: consecutive sample_en strobes a pattern must hold before it is accepted (legal range 1..15).
REQ-002 clk  input  1  single rising-edge clock; all state is in this domain.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 sample_en  input  1  sample strobe, synchronous to clk; may be held high continuously.
REQ-005 dec  input  7  active-low seven-segment bus, bit6 = a ... bit0 = g; asynchronous to clk.
REQ-006 bcd  output  3  last accepted digit value 0..7.
REQ-007 valid  output  1  one-cycle pulse when a new digit is accepted.
REQ-008 step_up / step_down  output  1 each  one-cycle pulses, coincident with valid, for +1 / -1 changes.
REQ-009 jump  output  1  one-cycle pulse, coincident with valid, for any other change from a previously accepted digit.
REQ-010 err  output  1  level; high while the FSM is in FAULT.
REQ-011 at_limit  output  1  level; high while in LOCKED and bcd is 0 or 7.

Function
REQ-012 dec passes through a 2-flop synchronizer; the filter sees the value 2 clk cycles after dec changes.
REQ-013 Decode table (active-low): 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F; every other pattern is invalid.
REQ-014 Filter: on sample_en, a synced pattern equal to the candidate increments a 4-bit stability count, saturating at STABLE_CYCLES; a different pattern loads the candidate and sets the count to 1.
REQ-015 A candidate is qualified in the cycle its count reaches STABLE_CYCLES; qualification fires once per candidate load.
REQ-016 FSM states INIT, LOCKED and FAULT; INIT is the reset state.
REQ-017 INIT, qualified valid pattern: update bcd, pulse valid only, go to LOCKED.
REQ-018 LOCKED, qualified valid pattern differing from bcd: update bcd, pulse valid and exactly one of step_up/step_down/jump.
REQ-019 Step rules: new = old+1 gives step_up; new = old-1 gives step_down; there is no wrap, so 7->0 and 0->7 are jump.
REQ-020 LOCKED, qualified pattern equal to the current bcd pattern: no pulses.
REQ-021 Any state, qualified invalid pattern: go to FAULT; bcd holds; no pulses.
REQ-022 FAULT, qualified valid pattern: update bcd, pulse valid only (no step or jump), go to LOCKED.
REQ-023 All outputs are registered; pulses occur 1 cycle after the qualifying sample_en edge.
REQ-024 sample_en low freezes the filter; the synchronizer keeps running.

Reset
REQ-025 While reset = 0, all registers clear asynchronously: synchronizer and candidate = 7'h7F, count = 0, state = INIT, bcd = 0, valid/step_up/step_down/jump/err/at_limit = 0.
REQ-026 Reset asserted mid-filter discards the candidate; after release, acceptance again needs a full STABLE_CYCLES run.

Configuration
REQ-027 Macro SEG_READER_STATS_EN defined: adds outputs up_cnt [7:0] and down_cnt [7:0].
REQ-028 up_cnt and down_cnt count step_up and step_down pulses, saturate at 255 and reset to 0.
REQ-029 Macro SEG_READER_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-030 Reset release, then dec = 7'h01 with sample_en high and STABLE_CYCLES = 4 -> valid pulse after 4 strobes plus 2 sync cycles, bcd = 0, at_limit = 1, no step pulse.
REQ-031 Locked at 3, dec -> 7'h4C (4) -> valid and step_up; then dec -> 7'h06 (3) -> valid and step_down; with STATS_EN, up_cnt = 1 and down_cnt = 1.
REQ-032 Locked at 7, dec -> 7'h01 (0) -> valid and jump, no step pulse, at_limit stays 1.
REQ-033 dec toggles between 7'h12 and 7'h06 every 3 strobes -> no valid pulse ever; bcd holds.
REQ-034 Stable 7'h7F -> err = 1 and bcd holds; then stable 7'h24 (5) -> err = 0, bcd = 5, valid pulse, no step or jump.
REQ-035 reset pulsed low after 2 of 4 strobes of a new pattern -> all outputs return to reset values; acceptance needs 4 fresh strobes.
